fp_mul_seq: RTL and testbench
=============================

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have parameter W, default 32, total word width.
REQ-002 SHALL have parameter M, default 22, MSB index of the stored fraction.
REQ-003 SHALL have parameter E, default 30, MSB index of the exponent field.
REQ-004 SHALL have clk, input, 1, the clock; all state updates on its rising edge.
REQ-005 SHALL have rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have act, input, 1, start request, sampled only in IDLE.
REQ-007 SHALL have in1 and in2, input, W each, IEEE-754 binary32 operands.
REQ-008 SHALL have round_m, input, 3: 000 RNe, 001 RZ, 010 RD, 011 RU, 100 RNa; other codes behave as RZ.
REQ-009 SHALL have out, output reg, W, product.
REQ-010 SHALL have ov, un, done, inv, div_zero, inexact, each an output reg of width 1: the exception flags and the completion pulse.

Function
REQ-011 SHALL implement FSM IDLE -> MUL -> NORM -> ROUND -> IDLE, plus SPECIAL -> IDLE.
REQ-012 IDLE with act=1 SHALL register in1, in2 and round_m; the registered values drive all later steps.
REQ-013 act while not IDLE SHALL be ignored; the operation in progress is not disturbed.
REQ-014 MUL SHALL do radix-2 shift-add over 24 cycles: {1,frac1} x {1,frac2} giving a 48-bit product.
REQ-015 Exponent SHALL be e1+e2-127, computed in a 10-bit signed register.
REQ-016 NORM: if product bit 47=1, shift right 1 and add 1 to the exponent; guard = next bit below the LSB; sticky = OR of all lower bits.
REQ-017 ROUND SHALL apply the registered mode; a mantissa carry-out SHALL increment the exponent.
REQ-018 Normal path: done SHALL pulse one cycle, 27 cycles after the act sample edge; out and flags update in the same cycle.
REQ-019 Special operands SHALL go to SPECIAL, with done 2 cycles after the act sample: a NaN input, or 0 x inf, gives out=0x7FC00000 with inv=1; inf x finite-nonzero gives signed inf; zero x finite gives signed zero.
REQ-020 Operands with exponent field 0 SHALL be treated as signed zero (flush).
REQ-021 Overflow (rounded exponent >254) SHALL set ov=1 and inexact=1; result is signed inf for RNe/RNa and for a directed mode toward that sign, else signed max-finite (0x7F7FFFFF magnitude).
REQ-022 Underflow (rounded exponent <1) SHALL set un=1 and inexact=1; result is signed zero.
REQ-023 inexact SHALL equal guard|sticky on the normal path; div_zero SHALL always be 0.
REQ-024 Result sign SHALL be in1[31]^in2[31] for every result, NaN excepted.
REQ-025 out and flags SHALL hold their values until the next done pulse; done is 0 except for the pulse cycle.

Reset
REQ-026 rst=0 SHALL force IDLE, out=0, all flags 0 and done=0 immediately, whatever the clock.
REQ-027 Reset mid-operation SHALL abandon the operation; no done pulse for it after rst is released.

Configuration
REQ-028 Macro FP_MUL_RNA_EN: when defined, round_m=100 rounds to nearest with ties away from zero.
REQ-029 When FP_MUL_RNA_EN is undefined, round_m=100 SHALL behave as RNe and no ties-away logic is built.

Verification
REQ-030 0x3FC00000 x 0x40000000, RNe -> done 27 cycles after act, out=0x40400000, inexact=0.
REQ-031 0x3F800001 x 0x3F800001 -> RNe out=0x3F800002 inexact=1; RU out=0x3F800003; RZ out=0x3F800002.
REQ-032 0x00000000 x 0x7F800000 -> done after 2 cycles, out=0x7FC00000, inv=1; 0xC0000000 x 0x7F800000 -> out=0xFF800000.
REQ-033 0x7F000000 x 0x40000000: RNe -> out=0x7F800000, ov=1, inexact=1; RZ -> out=0x7F7FFFFF, ov=1.
REQ-034 0x00800000 x 0x00800000 -> out=0x00000000, un=1, inexact=1; 0x80800000 x 0x00800000 -> out=0x80000000.
REQ-035 act pulsed on cycle 10 of MUL -> ignored, single done; rst low on cycle 12 -> outputs 0, no done afterward.

Source files
------------

// File: rtl/fp_mul_seq.sv
// fp_mul_seq -- sequential IEEE-754 binary32 multiplier.
//
// Operation: an act pulse in IDLE captures in1, in2 and round_m. Ordinary
// operands take MUL (24 shift-add steps), NORM, and ROUND (two cycles: round
// increment, then pack/exception handling). done pulses 27 cycles after the
// act sample edge. Special operands (NaN, infinity, zero or exponent field 0)
// take SPECIAL and finish 2 cycles after the act sample edge. Subnormal
// operands are flushed to signed zero. Results never underflow gradually:
// anything below the normal range becomes signed zero.
//
// Ports:
//   clk       in   clock, rising-edge active
//   rst       in   asynchronous active-low reset
//   act       in   start request, sampled only in IDLE
//   in1, in2  in   W-bit binary32 operands
//   round_m   in   3'b000 RNe, 001 RZ, 010 RD, 011 RU, 100 RNa, others RZ
//   out       out  W-bit product, held until the next done
//   ov, un, inv, div_zero, inexact  out  exception flags, held with out
//   done      out  one-cycle completion pulse
//
// Build option: define FP_MUL_RNA_EN to build ties-away rounding for
// round_m=100; when undefined that code rounds to nearest even.
module fp_mul_seq #(
  parameter int W = 32,
  parameter int M = 22,
  parameter int E = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         done,
  output logic         inv,
  output logic         div_zero,
  output logic         inexact
);

  localparam int FW = M + 1;       // stored fraction width
  localparam int EW = E - M;       // exponent field width
  localparam int MW = FW + 1;      // mantissa width including hidden bit
  localparam int PW = 2 * MW;      // full product width

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MUL     = 3'd1;
  localparam logic [2:0] S_NORM    = 3'd2;
  localparam logic [2:0] S_ROUND   = 3'd3;
  localparam logic [2:0] S_SPECIAL = 3'd4;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RZ  = 3'b001;
  localparam logic [2:0] RM_RD  = 3'b010;
  localparam logic [2:0] RM_RU  = 3'b011;
  localparam logic [2:0] RM_RNA = 3'b100;

  localparam logic [1:0] CL_NORM = 2'd0;
  localparam logic [1:0] CL_ZERO = 2'd1;
  localparam logic [1:0] CL_INF  = 2'd2;
  localparam logic [1:0] CL_NAN  = 2'd3;

  localparam logic [4:0] LAST_STEP = 5'(MW - 1);

  // Operand class from its exponent and fraction fields.
  function automatic logic [1:0] op_class(input logic [EW-1:0] ex, input logic [FW-1:0] fr);
    if (ex == {EW{1'b0}}) begin
      op_class = CL_ZERO;
    end else if (ex == {EW{1'b1}}) begin
      op_class = (fr == {FW{1'b0}}) ? CL_INF : CL_NAN;
    end else begin
      op_class = CL_NORM;
    end
  endfunction

  // Whether the truncated magnitude must be bumped by one ulp.
  function automatic logic rnd_inc(input logic [2:0] rm, input logic sgn, input logic lsb,
                                   input logic g, input logic s);
    case (rm)
      RM_RNE: rnd_inc = g & (s | lsb);
      RM_RZ:  rnd_inc = 1'b0;
      RM_RD:  rnd_inc = (g | s) & sgn;
      RM_RU:  rnd_inc = (g | s) & ~sgn;
`ifdef FP_MUL_RNA_EN
      RM_RNA: rnd_inc = g;
`else
      RM_RNA: rnd_inc = g & (s | lsb);
`endif
      default: rnd_inc = 1'b0;
    endcase
  endfunction

  // Whether an overflowing result saturates to infinity rather than max-finite.
  function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sgn);
    case (rm)
      RM_RNE:  ovf_to_inf = 1'b1;
      RM_RNA:  ovf_to_inf = 1'b1;
      RM_RD:   ovf_to_inf = sgn;
      RM_RU:   ovf_to_inf = ~sgn;
      default: ovf_to_inf = 1'b0;
    endcase
  endfunction

  logic [2:0]        state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [2:0]        rm_q, rm_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic signed [9:0] exp_q, exp_d;
  logic [FW-1:0]     frac_q, frac_d;
  logic              guard_q, guard_d, sticky_q, sticky_d;
  logic [W-1:0]      out_q, out_d;
  logic              ov_q, ov_d, un_q, un_d, inv_q, inv_d, inexact_q, inexact_d, done_q, done_d;

  logic              sign_s;
  logic              in_special_s;
  logic [PW-1:0]     a_ext_s;
  logic [MW-1:0]     b_man_s;
  logic [PW-1:0]     partial_s;
  logic signed [9:0] exp_sum_s;
  logic              inc_s;
  logic [FW:0]       frac_sum_s;
  logic [1:0]        cls_a_s, cls_b_s;

  assign sign_s       = a_q[W-1] ^ b_q[W-1];
  assign in_special_s = (op_class(in1[E:M+1], in1[M:0]) != CL_NORM) ||
                        (op_class(in2[E:M+1], in2[M:0]) != CL_NORM);
  assign a_ext_s      = {{(PW-MW){1'b0}}, 1'b1, a_q[M:0]};
  assign b_man_s      = {1'b1, b_q[M:0]};
  // Step cnt_q adds multiplicand << cnt_q when multiplier bit cnt_q is set.
  assign partial_s    = b_man_s[cnt_q] ? (a_ext_s << cnt_q) : {PW{1'b0}};
  assign exp_sum_s    = $signed({2'b00, a_q[E:M+1]}) + $signed({2'b00, b_q[E:M+1]}) - 10'sd127;
  assign inc_s        = rnd_inc(rm_q, sign_s, frac_q[0], guard_q, sticky_q);
  // A carry out of the fraction means 1.11..1 rounded up to 10.00..0:
  // the fraction bits are already zero, only the exponent moves.
  assign frac_sum_s   = {1'b0, frac_q} + {{FW{1'b0}}, inc_s};
  assign cls_a_s      = op_class(a_q[E:M+1], a_q[M:0]);
  assign cls_b_s      = op_class(b_q[E:M+1], b_q[M:0]);

  // Next-state and datapath logic for the whole sequence.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rm_d      = rm_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    prod_d    = prod_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    out_d     = out_q;
    ov_d      = ov_q;
    un_d      = un_q;
    inv_d     = inv_q;
    inexact_d = inexact_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (act) begin
          a_d     = in1;
          b_d     = in2;
          rm_d    = round_m;
          cnt_d   = 5'd0;
          phase_d = 1'b0;
          prod_d  = {PW{1'b0}};
          state_d = in_special_s ? S_SPECIAL : S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        prod_d = prod_q + partial_s;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd0) begin
          exp_d = exp_sum_s;
        end else begin
          exp_d = exp_q;
        end
        if (cnt_q == LAST_STEP) begin
          state_d = S_NORM;
        end else begin
          state_d = S_MUL;
        end
      end
      S_NORM: begin
        // Product of two [1,2) mantissas lies in [1,4); bit PW-1 marks [2,4).
        if (prod_q[PW-1]) begin
          frac_d   = prod_q[PW-2:MW];
          guard_d  = prod_q[MW-1];
          sticky_d = |prod_q[MW-2:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          frac_d   = prod_q[PW-3:MW-1];
          guard_d  = prod_q[MW-2];
          sticky_d = |prod_q[MW-3:0];
          exp_d    = exp_q;
        end
        phase_d = 1'b0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (!phase_q) begin
          frac_d  = frac_sum_s[FW-1:0];
          exp_d   = frac_sum_s[FW] ? (exp_q + 10'sd1) : exp_q;
          phase_d = 1'b1;
          state_d = S_ROUND;
        end else begin
          inv_d  = 1'b0;
          done_d = 1'b1;
          if (exp_q > 10'sd254) begin
            ov_d      = 1'b1;
            un_d      = 1'b0;
            inexact_d = 1'b1;
            if (ovf_to_inf(rm_q, sign_s)) begin
              out_d = {sign_s, {EW{1'b1}}, {FW{1'b0}}};
            end else begin
              out_d = {sign_s, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
            end
          end else if (exp_q < 10'sd1) begin
            ov_d      = 1'b0;
            un_d      = 1'b1;
            inexact_d = 1'b1;
            out_d     = {sign_s, {(W-1){1'b0}}};
          end else begin
            ov_d      = 1'b0;
            un_d      = 1'b0;
            inexact_d = guard_q | sticky_q;
            out_d     = {sign_s, exp_q[EW-1:0], frac_q};
          end
          phase_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_SPECIAL: begin
        if (!phase_q) begin
          phase_d = 1'b1;
          state_d = S_SPECIAL;
        end else begin
          ov_d      = 1'b0;
          un_d      = 1'b0;
          inexact_d = 1'b0;
          done_d    = 1'b1;
          if ((cls_a_s == CL_NAN) || (cls_b_s == CL_NAN) ||
              ((cls_a_s == CL_ZERO) && (cls_b_s == CL_INF)) ||
              ((cls_a_s == CL_INF) && (cls_b_s == CL_ZERO))) begin
            inv_d = 1'b1;
            out_d = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
          end else if ((cls_a_s == CL_INF) || (cls_b_s == CL_INF)) begin
            inv_d = 1'b0;
            out_d = {sign_s, {EW{1'b1}}, {FW{1'b0}}};
          end else begin
            inv_d = 1'b0;
            out_d = {sign_s, {(W-1){1'b0}}};
          end
          phase_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= {W{1'b0}};
      b_q       <= {W{1'b0}};
      rm_q      <= 3'd0;
      cnt_q     <= 5'd0;
      phase_q   <= 1'b0;
      prod_q    <= {PW{1'b0}};
      exp_q     <= 10'sd0;
      frac_q    <= {FW{1'b0}};
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      out_q     <= {W{1'b0}};
      ov_q      <= 1'b0;
      un_q      <= 1'b0;
      inv_q     <= 1'b0;
      inexact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rm_q      <= rm_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      prod_q    <= prod_d;
      exp_q     <= exp_d;
      frac_q    <= frac_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      out_q     <= out_d;
      ov_q      <= ov_d;
      un_q      <= un_d;
      inv_q     <= inv_d;
      inexact_q <= inexact_d;
      done_q    <= done_d;
    end
  end

  assign out      = out_q;
  assign ov       = ov_q;
  assign un       = un_q;
  assign inv      = inv_q;
  assign inexact  = inexact_q;
  assign done     = done_q;
  assign div_zero = 1'b0;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: the driver pushes reference results into a
// queue, a monitor pops and compares whenever done is seen.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        act;
  logic [31:0] in1, in2;
  logic [2:0]  round_m;
  logic [31:0] out;
  logic        ov, un, done, inv, div_zero, inexact;

  fp_mul_seq dut (
    .clk(clk), .rst(rst), .act(act), .in1(in1), .in2(in2), .round_m(round_m),
    .out(out), .ov(ov), .un(un), .done(done), .inv(inv), .div_zero(div_zero),
    .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o;
    logic        ov, un, inv, inx;
    int          lat;
    int          sample;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_out;
  bit          have_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
  endtask

  // Reference: exact integer product, rounding decided by comparing the
  // discarded remainder with half an ulp.
  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                           output exp_t r);
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, kept, rem, half;
    bit s, up, na, nb, za, zb, ia, ib;
    logic [2:0] mode;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 23'd0);
    nb = (eb == 255) && (b[22:0] != 23'd0);
    ia = (ea == 255) && (a[22:0] == 23'd0);
    ib = (eb == 255) && (b[22:0] == 23'd0);
    za = (ea == 0);
    zb = (eb == 0);
    r.ov = 1'b0; r.un = 1'b0; r.inv = 1'b0; r.inx = 1'b0; r.lat = 2; r.sample = 0;
    if (na || nb || (za && ib) || (ia && zb)) begin
      r.o = 32'h7FC00000;
      r.inv = 1'b1;
    end else if (ia || ib) begin
      r.o = {s, 8'hFF, 23'd0};
    end else if (za || zb) begin
      r.o = {s, 31'd0};
    end else begin
      r.lat = 27;
      ma = (64'd1 << 23) + 64'(a[22:0]);
      mb = (64'd1 << 23) + 64'(b[22:0]);
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
      else sh = 23;
      kept = p >> sh;
      rem  = p - (kept << sh);
      half = 64'd1 << (sh - 1);
      mode = rm;
`ifndef FP_MUL_RNA_EN
      if (mode == 3'd4) mode = 3'd0;
`endif
      if (mode > 3'd4) mode = 3'd1;
      case (mode)
        3'd0: up = (rem > half) || ((rem == half) && kept[0]);
        3'd2: up = (rem != 0) && s;
        3'd3: up = (rem != 0) && !s;
        3'd4: up = (rem >= half);
        default: up = 1'b0;
      endcase
      kept = kept + 64'(up);
      if (kept == (64'd1 << 24)) begin kept = kept >> 1; e = e + 1; end
      if (e > 254) begin
        r.ov = 1'b1; r.inx = 1'b1;
        if (mode == 3'd0 || mode == 3'd4 || (mode == 3'd3 && !s) || (mode == 3'd2 && s))
          r.o = {s, 8'hFF, 23'd0};
        else
          r.o = {s, 8'hFE, 23'h7FFFFF};
      end else if (e < 1) begin
        r.un = 1'b1; r.inx = 1'b1;
        r.o = {s, 31'd0};
      end else begin
        r.inx = (rem != 0);
        r.o = {s, 8'(e), kept[22:0]};
      end
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 with out=%h, want no pending op", out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out", out, mon_e.o);
        chk("flags{ov,un,inv,dz,inx}", {27'd0, ov, un, inv, div_zero, inexact},
            {27'd0, mon_e.ov, mon_e.un, mon_e.inv, 1'b0, mon_e.inx});
        chk("latency", 32'(cyc - mon_e.sample), 32'(mon_e.lat));
        last_out  = mon_e.o;
        have_last = 1'b1;
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input bit push);
    exp_t r;
    if (have_last) chk("hold", out, last_out);
    @(negedge clk);
    in1 = a; in2 = b; round_m = rm; act = 1'b1;
    ref_model(a, b, rm, r);
    r.sample = cyc + 1;
    if (push) sb_q.push_back(r);
    @(negedge clk);
    act = 1'b0;
    in1 = $urandom; in2 = $urandom; round_m = 3'($urandom);
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0]  ex;
    logic [22:0] fr;
    int sel;
    sel = $urandom_range(0, 11);
    fr  = 23'($urandom);
    case (sel)
      0: ex = 8'd0;
      1: begin ex = 8'hFF; if ($urandom_range(0, 1) == 0) fr = 23'd0; end
      2: ex = 8'($urandom_range(1, 6));
      3: ex = 8'($urandom_range(249, 254));
      default: ex = 8'($urandom_range(64, 190));
    endcase
    return {1'($urandom), ex, fr};
  endfunction

  initial begin
    rst = 1'b0; act = 1'b0; in1 = 32'd0; in2 = 32'd0; round_m = 3'd0;
    #1;
    chk("reset_out", out, 32'd0);
    chk("reset_flags", {26'd0, ov, un, inv, div_zero, inexact, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_op(32'h3FC00000, 32'h40000000, 3'd0, 1'b1); wait_done();
    do_op(32'h3F800001, 32'h3F800001, 3'd0, 1'b1); wait_done();
    do_op(32'h3F800001, 32'h3F800001, 3'd3, 1'b1); wait_done();
    do_op(32'h3F800001, 32'h3F800001, 3'd1, 1'b1); wait_done();
    do_op(32'h00000000, 32'h7F800000, 3'd0, 1'b1); wait_done();
    do_op(32'hC0000000, 32'h7F800000, 3'd0, 1'b1); wait_done();
    do_op(32'h7F000000, 32'h40000000, 3'd0, 1'b1); wait_done();
    do_op(32'h7F000000, 32'h40000000, 3'd1, 1'b1); wait_done();
    do_op(32'h00800000, 32'h00800000, 3'd0, 1'b1); wait_done();
    do_op(32'h80800000, 32'h00800000, 3'd0, 1'b1); wait_done();
    do_op(32'h3FC00000, 32'h3F800003, 3'd0, 1'b1); wait_done();
    do_op(32'h3FC00000, 32'h3F800003, 3'd4, 1'b1); wait_done();
    do_op(32'h7FC00001, 32'h3F800000, 3'd2, 1'b1); wait_done();

    // act during MUL cycle 10 must be ignored; only one done may appear.
    do_op(32'h40490FDB, 32'hC02DF854, 3'd0, 1'b1);
    repeat (8) @(negedge clk);
    in1 = 32'h3F800000; in2 = 32'h3F800000; act = 1'b1;
    @(negedge clk);
    act = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);

    // Reset in MUL cycle 12: outputs clear at once, the op never completes.
    do_op(32'h41200000, 32'h41A00000, 3'd0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_out", out, 32'd0);
    chk("midreset_flags", {26'd0, ov, un, inv, div_zero, inexact, done}, 32'd0);
    have_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      do_op(rand_op(), rand_op(), 3'($urandom_range(0, 7)), 1'b1);
      wait_done();
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
